// File: rtl/demux4_tdm.sv
// demux4_tdm: serial TDM bitstream demultiplexer, four channels.
// Hunts for frame_sync, then reassembles one W-bit word per channel.
module demux4_tdm #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         out_valid,
  output logic         locked,
  output logic         sync_err
);

  localparam int BW = (W > 2) ? $clog2(W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [1:0]          slot_q, slot_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [3:0][W-1:0]   sh_q, sh_d;
  logic [3:0][W-1:0]   ch_q, ch_d;
  logic                ov_q, ov_d;
  logic                se_q, se_d;

  logic capture;
  logic realign;
  logic run_beat;
  logic restart;

  assign capture  = din_valid && frame_sync
                 && (state_q == HUNT);
  assign realign  = din_valid && frame_sync
                 && (state_q == RUN)
                 && (slot_q != 2'd0);
  assign restart  = capture || realign;
  assign run_beat = din_valid && (state_q == RUN)
                 && !realign;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave HUNT on the first synced beat, never drop RUN
  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = RUN;
    end
  end

  // Datapath next values: restart on sync, else shift and count
  always_comb begin
    slot_d = slot_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    ch_d   = ch_q;
    ov_d   = 1'b0;
    se_d   = 1'b0;
    unique case (1'b1)
      restart: begin
        sh_d    = '0;
        sh_d[0] = {{(W-1){1'b0}}, din};
        slot_d  = 2'd1;
        bit_d   = '0;
        se_d    = realign;
      end
      run_beat: begin
        sh_d[slot_q] = {sh_q[slot_q][W-2:0], din};
        slot_d       = slot_q + 2'd1;
        if (slot_q == 2'd3) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            ch_d  = sh_d;
            ov_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        slot_d = slot_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      ch_q   <= '0;
      ov_q   <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      ch_q   <= ch_d;
      ov_q   <= ov_d;
      se_q   <= se_d;
    end
  end

  // Outputs straight from registers
  always_comb begin
    locked    = (state_q == RUN);
    out_valid = ov_q;
    sync_err  = se_q;
    ch0       = ch_q[0];
    ch1       = ch_q[1];
    ch2       = ch_q[2];
    ch3       = ch_q[3];
  end

endmodule

// File: tb/tb_demux4_tdm.sv
// tb_demux4_tdm: directed and random checks of demux4_tdm
// against a frame-position reference model.
module tb_demux4_tdm;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic         out_valid;
  logic         locked;
  logic         sync_err;

  demux4_tdm #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .out_valid  (out_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state: frame position p counts beats since sync (0..4W-1)
  bit           m_lock;
  int           m_p;
  logic [W-1:0] m_w [4];
  logic [W-1:0] e_ch [4];
  logic         e_ov;
  logic         e_se;

  int ov_cnt;
  int se_cnt;
  int cyc;
  int ov_cyc [$];

  logic [W-1:0] pat [4];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0;
    m_p    = 0;
    e_ov   = 1'b0;
    e_se   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_w[i]  = '0;
      e_ch[i] = '0;
    end
  endtask

  task automatic model_put(input int p, input logic d);
    m_w[p % 4][W - 1 - p / 4] = d;
  endtask

  task automatic model_beat(input logic v,
                            input logic f,
                            input logic d);
    e_ov = 1'b0;
    e_se = 1'b0;
    if (v) begin
      if (!m_lock) begin
        if (f) begin
          m_lock = 1'b1;
          for (int i = 0; i < 4; i++) m_w[i] = '0;
          model_put(0, d);
          m_p = 1;
        end
      end else if (f && (m_p % 4) != 0) begin
        e_se = 1'b1;
        for (int i = 0; i < 4; i++) m_w[i] = '0;
        model_put(0, d);
        m_p = 1;
      end else begin
        model_put(m_p, d);
        m_p++;
        if (m_p == 4 * W) begin
          e_ov = 1'b1;
          for (int i = 0; i < 4; i++) e_ch[i] = m_w[i];
          m_p = 0;
        end
      end
    end
  endtask

  task automatic check_outs();
    chk("locked", locked, m_lock);
    chk("out_valid", out_valid, e_ov);
    chk("sync_err", sync_err, e_se);
    chk("ch0", ch0, e_ch[0]);
    chk("ch1", ch1, e_ch[1]);
    chk("ch2", ch2, e_ch[2]);
    chk("ch3", ch3, e_ch[3]);
  endtask

  task automatic step(input logic v,
                      input logic f,
                      input logic d);
    din        = d;
    din_valid  = v;
    frame_sync = f;
    @(posedge clk);
    model_beat(v, f, d);
    cyc++;
    #1;
    if (out_valid) begin
      ov_cnt++;
      ov_cyc.push_back(cyc);
    end
    if (sync_err) se_cnt++;
    check_outs();
  endtask

  task automatic clr_counts();
    ov_cnt = 0;
    se_cnt = 0;
    ov_cyc.delete();
  endtask

  // beat k of the reference stream: slot k%4, bit k/4 MSB first
  function automatic logic pat_bit(input int k);
    logic [W-1:0] w;
    w = pat[k % 4];
    return w[W - 1 - k / 4];
  endfunction

  task automatic send_stream(input int nbeats, input int gap);
    for (int k = 0; k < nbeats; k++) begin
      step(1'b1, k == 0, pat_bit(k));
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b0, 1'($urandom_range(1)));
      end
    end
  endtask

  task automatic check_pat(input string tag);
    chk({tag, "_ch0"}, ch0, 4'b1011);
    chk({tag, "_ch1"}, ch1, 4'b0110);
    chk({tag, "_ch2"}, ch2, 4'b1111);
    chk({tag, "_ch3"}, ch3, 4'b0001);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_locked", locked, 1'b0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_se", sync_err, 1'b0);
    chk("rst_ch0", ch0, '0);
    chk("rst_ch1", ch1, '0);
    chk("rst_ch2", ch2, '0);
    chk("rst_ch3", ch3, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    pat[0] = 4'b1011;
    pat[1] = 4'b0110;
    pat[2] = 4'b1111;
    pat[3] = 4'b0001;
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    cyc        = 0;
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    rst_n = 1'b1;

    // back-to-back synced word
    clr_counts();
    step(1'b1, 1'b1, pat_bit(0));
    chk("s1_locked_c2", locked, 1'b1);
    for (int k = 1; k < 16; k++) step(1'b1, 1'b0, pat_bit(k));
    chk("s1_ov_now", out_valid, 1'b1);
    check_pat("s1");
    step(1'b0, 1'b0, 1'b0);
    chk("s1_ov_once", ov_cnt, 1);

    // same word with 3 idle cycles between beats
    clr_counts();
    send_stream(16, 3);
    chk("s2_ov_cnt", ov_cnt, 1);
    check_pat("s2");

    // unsynced beats before sync are ignored
    do_reset();
    clr_counts();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'($urandom_range(1)));
      chk("s3_unlocked", locked, 1'b0);
    end
    send_stream(16, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("s3_ov_cnt", ov_cnt, 1);
    check_pat("s3");

    // misaligned sync at slot 2 of frame 3, then all ones
    clr_counts();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 1'($urandom_range(1)));
    end
    for (int k = 0; k < 16; k++) step(1'b1, k == 0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("s4_se_cnt", se_cnt, 1);
    chk("s4_ov_cnt", ov_cnt, 1);
    chk("s4_ch0", ch0, 4'b1111);
    chk("s4_ch3", ch3, 4'b1111);

    // reset after beat 9, then fresh stream
    clr_counts();
    send_stream(9, 0);
    do_reset();
    send_stream(16, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("s5_ov_cnt", ov_cnt, 1);
    check_pat("s5");

    // two consecutive words, sync on first beat only
    clr_counts();
    for (int k = 0; k < 32; k++) step(1'b1, k == 0, pat_bit(k % 16));
    step(1'b0, 1'b0, 1'b0);
    chk("s6_ov_cnt", ov_cnt, 2);
    chk("s6_se_cnt", se_cnt, 0);
    if (ov_cyc.size() == 2) begin
      chk("s6_ov_gap", ov_cyc[1] - ov_cyc[0], 16);
    end else begin
      chk("s6_ov_gap_n", ov_cyc.size(), 2);
    end

    // random traffic with occasional sync and idle gaps
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(99) < 75,
           $urandom_range(99) < 4,
           1'($urandom_range(1)));
      if (k == 1500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux4_tdm.md
DEMUX4_TDM -- requirements
Module: demux4_tdm

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the word width in bits reassembled per channel; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port din, input, 1 bit: the serial time-division-multiplexed data bit.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din is valid this cycle (one beat).
REQ-006 The block SHALL have port frame_sync, input, 1 bit: marks the current beat as slot 0; it SHALL be qualified by din_valid.
REQ-007 The block SHALL have ports ch0, ch1, ch2 and ch3, each output, W bits: the last completed word per channel, registered.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse when ch0..ch3 update.
REQ-009 The block SHALL have port locked, output, 1 bit: high while the state machine is in RUN.
REQ-010 The block SHALL have port sync_err, output, 1 bit: a one-cycle pulse on a misaligned frame_sync.

Function
REQ-011 The block SHALL use states HUNT and RUN, a 2-bit slot counter and a bit counter of ceil(log2 W) bits.
REQ-012 In HUNT, beats without frame_sync SHALL be discarded.
REQ-013 In HUNT, a beat with frame_sync=1 SHALL be captured as slot 0, bit 0; the state SHALL go to RUN, slot SHALL become 1, and locked SHALL be 1 from the next cycle.
REQ-014 In RUN, each valid beat SHALL shift din into the shift register of channel[slot], MSB first (shreg <= {shreg[W-2:0], din}).
REQ-015 In RUN, slot SHALL increment by one per beat, wrapping 3 -> 0.
REQ-016 Slot mapping SHALL be: slot 0 -> ch0, slot 1 -> ch1, slot 2 -> ch2, slot 3 -> ch3.
REQ-017 The bit counter SHALL increment on each slot 3 beat, wrapping (W-1) -> 0.
REQ-018 On the beat where slot=3 and the bit counter is W-1, all four completed words (including the current bit) SHALL load into ch0..ch3, and out_valid SHALL be 1 in the following cycle only.
REQ-019 The latency from the final beat edge to the out_valid and channel update SHALL be 1 clock.
REQ-020 Cycles with din_valid=0 SHALL hold all state; gaps between beats SHALL NOT affect data.
REQ-021 frame_sync with valid in RUN at slot=0 SHALL be treated as a normal beat with no error.
REQ-022 frame_sync with valid in RUN at slot!=0 SHALL: pulse sync_err next cycle; clear all four shift registers and the bit counter; capture the beat as slot 0, bit 0; set slot to 1; and remain in RUN.
REQ-023 On a misaligned frame_sync, ch0..ch3 SHALL retain their previous values and out_valid SHALL NOT pulse.
REQ-024 frame_sync while din_valid=0 SHALL be ignored.
REQ-025 A realignment on the same beat that would complete a word SHALL take priority: there SHALL be no out_valid and only sync_err.
REQ-026 ch0..ch3 SHALL change only together with an out_valid pulse.

Reset
REQ-027 When rst_n=0, the block SHALL immediately, without waiting for clk, force state=HUNT, slot=0, bit counter=0, all shift registers=0, ch0..ch3=0, out_valid=0, locked=0 and sync_err=0.
REQ-028 After rst_n deasserts, operation SHALL resume from HUNT on the first rising clk edge.
REQ-029 Reset asserted mid-word SHALL discard the partial word, and ch0..ch3 SHALL read 0.

Verification
REQ-030 With W=4, send frame_sync on beat 0, then 16 back-to-back beats with ch0 bits 1,0,1,1, ch1 bits 0,1,1,0, ch2 bits 1,1,1,1 and ch3 bits 0,0,0,1, interleaved by slot. The bench SHALL check: one out_valid pulse 1 cycle after beat 16, ch0=1011, ch1=0110, ch2=1111, ch3=0001, locked=1 from cycle 2.
REQ-031 Repeat the REQ-030 stream with din_valid=0 for 3 cycles between every beat; the bench SHALL check identical ch0..ch3 values and exactly one out_valid pulse.
REQ-032 Send 5 beats without frame_sync, then the REQ-030 stream; the bench SHALL check that the first 5 beats are ignored, locked=0 until sync, and results match REQ-030.
REQ-033 In RUN, assert frame_sync at slot 2 of frame 3, then send a full 16-beat stream of all ones. The bench SHALL check: sync_err pulses once, there is no out_valid for the aborted word, then out_valid with ch0..ch3=1111.
REQ-034 Assert rst_n=0 for 1 cycle after beat 9 of a word; the bench SHALL check that all outputs are 0 asynchronously and locked=0, and that a subsequent fresh synced stream decodes correctly.
REQ-035 Run two consecutive 16-beat words with frame_sync only on the first beat; the bench SHALL check two out_valid pulses 16 beats apart with no sync_err.
